// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline register family.
//   state_t            : handshake FSM encoding of pipe_skid_reg
//   DEFAULT_DATA_WIDTH : default payload bundle width
//   DEFAULT_CNT_WIDTH  : default width of performance/stall counters
// -----------------------------------------------------------------------------
package pipe_pkg;

    // EMPTY: nothing held; FULL: main register valid; SKID: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance debug. Counts cycles where inc=1,
// sticks at all-ones, and clears synchronously (clear beats increment).
// Ports:
//   clk   in   core clock, rising edge
//   rst_n in   synchronous active-low reset, count -> 0
//   inc   in   count this cycle
//   clr   in   synchronous clear, count -> 0 next cycle
//   count out  WIDTH-bit counter value (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Inter-stage pipeline register with a 2-entry skid buffer. in_ready is a
// decode of the state register only, so downstream back-pressure never forms
// a combinational path to the upstream stage. Supports a squash (flush) and a
// saturating stall-cycle counter.
// Ports:
//   clk           in   core clock, rising edge
//   rst_n         in   synchronous active-low reset
//   flush         in   drop all held beats and the incoming beat this cycle
//   in_valid      in   upstream beat present
//   in_ready      out  register can accept a beat (state != SKID)
//   in_data       in   upstream payload
//   out_valid     out  beat presented downstream (state != EMPTY)
//   out_ready     in   downstream accepts the beat
//   out_data      out  downstream payload, straight from the main register
//   clr_stall_cnt in   synchronous clear of stall_cnt
//   stall_cnt     out  saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  clr_stall_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  stall_inc;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_d  = in_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    // Main beat leaves; refill it directly or drain to EMPTY.
                    if (in_valid) begin
                        main_d = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (in_valid) begin
                    // in_ready was already 1, so this beat must be caught.
                    skid_d  = in_data;
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                // in_ready=0 here, so in_data is ignored.
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Squash: invalidate everything and drop the incoming beat. A
        // downstream handshake this cycle has still completed. Data contents
        // are don't-care while invalid, so they are simply held.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign stall_inc = out_valid & ~out_ready;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (clr_stall_cnt),
        .count (stall_cnt)
    );

endmodule : pipe_skid_reg
